// File: rtl/c_mem_pkg.sv
// Shared constants, command encodings and controller states for the
// coefficient memory controller.
package c_mem_pkg;
  localparam int RAM_WIDTH     = 12;
  localparam int RAM_ADDR_BITS = 10;
  localparam int N             = 757;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DUMP
  } state_e;
endpackage

// File: rtl/c_mem_ctrl_if.sv
// Command, load-stream and dump-stream handshakes of the coefficient controller.
interface c_mem_ctrl_if import c_mem_pkg::*; #(
  parameter int W = c_mem_pkg::RAM_WIDTH
) ();
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         done;
  logic         busy;

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, done, busy
  );

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, done, busy
  );
endinterface

// File: rtl/c.sv
// Coefficient RAM: synchronous write, combinational read.
module c #(
  parameter int RAM_WIDTH     = c_mem_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = c_mem_pkg::RAM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] write_address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_ADDR_BITS-1:0] read_address,
  output logic [RAM_WIDTH-1:0]     output_data
);
  logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];

  always_ff @(posedge clk)
    if (write_enable) mem[write_address] <= input_data;

  assign output_data = mem[read_address];
endmodule

// File: rtl/c_mem_sub.sv
// Controller plus its coefficient RAM.
module c_mem_sub import c_mem_pkg::*; #(
  parameter int RAM_WIDTH     = c_mem_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = c_mem_pkg::RAM_ADDR_BITS,
  parameter int N             = c_mem_pkg::N
) (
  input logic         clk,
  input logic         rst,
  c_mem_ctrl_if.slave bus
);
  logic                     we;
  logic [RAM_ADDR_BITS-1:0] waddr, raddr;
  logic [RAM_WIDTH-1:0]     wdata, rdata;

  c_mem_ctrl #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS), .N(N)) u_ctrl (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_write_enable(we), .ram_write_address(waddr), .ram_input_data(wdata),
    .ram_read_address(raddr), .ram_output_data(rdata)
  );

  c #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS)) u_ram (
    .clk(clk), .write_enable(we), .write_address(waddr), .input_data(wdata),
    .read_address(raddr), .output_data(rdata)
  );
endmodule

// File: rtl/c_mem_ctrl.sv
// Coefficient memory controller: CLEAR/LOAD/DUMP sweeps of addresses 0..N-1
// over an external RAM.
module c_mem_ctrl import c_mem_pkg::*; #(
  parameter int RAM_WIDTH     = c_mem_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = c_mem_pkg::RAM_ADDR_BITS,
  parameter int N             = c_mem_pkg::N
) (
  input  logic                     clk,
  input  logic                     rst,
  c_mem_ctrl_if.slave              bus,
  output logic                     ram_write_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_write_address,
  output logic [RAM_WIDTH-1:0]     ram_input_data,
  output logic [RAM_ADDR_BITS-1:0] ram_read_address,
  input  logic [RAM_WIDTH-1:0]     ram_output_data
);
  localparam logic [RAM_ADDR_BITS-1:0] LAST = RAM_ADDR_BITS'(N - 1);

  state_e                   state, state_n;
  logic [RAM_ADDR_BITS-1:0] idx, idx_n;
  logic                     done_q, done_n;
  logic                     xfer;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      done_q <= done_n;
    end

  always_comb begin
    state_n          = state;
    idx_n            = idx;
    done_n           = 1'b0;
    xfer             = 1'b0;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    ram_write_enable = 1'b0;
    ram_input_data   = '0;
    case (state)
      S_IDLE:
        if (bus.cmd_valid) begin
          idx_n = '0;
          case (cmd_op_e'(bus.cmd_op))
            OP_CLEAR: state_n = S_CLEAR;
            OP_LOAD:  state_n = S_LOAD;
            OP_DUMP:  state_n = S_DUMP;
            default:  done_n  = 1'b1;  // reserved op: swallow and report done
          endcase
        end
      S_CLEAR: begin
        ram_write_enable = 1'b1;
        xfer             = 1'b1;
      end
      S_LOAD: begin
        bus.in_ready     = 1'b1;
        ram_write_enable = bus.in_valid;
        ram_input_data   = bus.in_data;
        xfer             = bus.in_valid;
      end
      S_DUMP: begin
        bus.out_valid = 1'b1;
        bus.out_data  = ram_output_data;
        xfer          = bus.out_ready;
      end
      default: state_n = S_IDLE;
    endcase
    // last transfer wraps idx back to 0 so it never reaches N
    if (xfer) begin
      if (idx == LAST) begin
        state_n = S_IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  assign bus.cmd_ready     = (state == S_IDLE);
  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = done_q;
  assign ram_write_address = idx;
  assign ram_read_address  = idx;
endmodule

// File: tb/tb_c_mem_ctrl.sv
// Bench for c_mem_ctrl: random stimulus against an array model of RAM contents.
module tb_c_mem_ctrl;
  import c_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [9:0]  waddr, raddr;
  logic [11:0] wdata, rdata;
  int          tests = 0;
  int          errors = 0;
  logic [11:0] ref_mem [0:1023];
  logic [9:0]  wr_a [$];
  logic [11:0] wr_d [$];

  always #5 clk = ~clk;

  c_mem_ctrl_if bus ();
  c_mem_ctrl_if sif ();

  c_mem_ctrl #(.RAM_WIDTH(12), .RAM_ADDR_BITS(10), .N(757)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_write_enable(we), .ram_write_address(waddr), .ram_input_data(wdata),
    .ram_read_address(raddr), .ram_output_data(rdata)
  );

  c #(.RAM_WIDTH(12), .RAM_ADDR_BITS(10)) u_ram (
    .clk(clk), .write_enable(we), .write_address(waddr), .input_data(wdata),
    .read_address(raddr), .output_data(rdata)
  );

  // wrapper instance kept idle; only its reset state is looked at
  c_mem_sub u_sub (.clk(clk), .rst(rst), .bus(sif));
  assign sif.cmd_valid = 1'b0;
  assign sif.cmd_op    = 2'b00;
  assign sif.in_valid  = 1'b0;
  assign sif.in_data   = 12'h0;
  assign sif.out_ready = 1'b0;

  always @(posedge clk)
    if (!rst && we) begin
      wr_a.push_back(waddr);
      wr_d.push_back(wdata);
    end

  task automatic issue(input logic [1:0] op);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready op=%0d got %0b want 1", op, bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_dump(input bit rnd);
    int k, t;
    bit rdy, stalled;
    logic [11:0] prev;
    k = 0; t = 0; stalled = 0; prev = '0;
    while (k < N && t < 8 * N) begin
      @(negedge clk);
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.out_ready = rdy;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || raddr !== 10'(k)) begin
        errors++;
        $display("FAIL dump_ctl k=%0d valid=%0b busy=%0b raddr=%0d want 1 1 %0d",
                 k, bus.out_valid, bus.busy, raddr, k);
      end
      tests++;
      if (bus.out_data !== ref_mem[k]) begin
        errors++; $display("FAIL dump_data k=%0d got %0d want %0d", k, bus.out_data, ref_mem[k]);
      end
      if (stalled) begin
        tests++;
        if (bus.out_data !== prev) begin
          errors++; $display("FAIL dump_hold k=%0d got %0d want %0d", k, bus.out_data, prev);
        end
      end
      prev = bus.out_data; stalled = !rdy;
      if (rdy) k++;
      t++;
    end
    tests++;
    if (k != N) begin
      errors++; $display("FAIL dump_timeout transfers %0d want %0d", k, N);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL dump_done done=%0b busy=%0b valid=%0b want 1 0 0",
                         bus.done, bus.busy, bus.out_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL dump_single_done got %0b want 0", bus.done);
    end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rst_status ready=%0b busy=%0b done=%0b want 1 0 0",
                         bus.cmd_ready, bus.busy, bus.done);
    end
    tests++;
    if (we !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_strobes we=%0b in_ready=%0b out_valid=%0b want 0 0 0",
                         we, bus.in_ready, bus.out_valid);
    end
    tests++;
    if (waddr !== 10'd0 || raddr !== 10'd0 || wdata !== 12'd0 || bus.out_data !== 12'd0) begin
      errors++; $display("FAIL rst_data waddr=%0d raddr=%0d wdata=%0d out=%0d want 0",
                         waddr, raddr, wdata, bus.out_data);
    end
    tests++;
    if (sif.cmd_ready !== 1'b1 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL rst_wrapper ready=%0b busy=%0b want 1 0", sif.cmd_ready, sif.busy);
    end
  endtask

  task automatic test_clear;
    bit bad;
    wr_a.delete(); wr_d.delete();
    issue(OP_CLEAR);
    for (int c = 0; c < N; c++) begin
      @(negedge clk); #1;
      tests++;
      if (we !== 1'b1 || waddr !== 10'(c) || wdata !== 12'd0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL clear_cycle c=%0d we=%0b addr=%0d data=%0d busy=%0b",
                           c, we, waddr, wdata, bus.busy);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL clear_done done=%0b busy=%0b we=%0b want 1 0 0", bus.done, bus.busy, we);
    end
    @(negedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL clear_after done=%0b busy=%0b want 0 0", bus.done, bus.busy);
    end
    bad = (wr_a.size() != N);
    if (!bad) for (int i = 0; i < N; i++) if (wr_a[i] !== 10'(i) || wr_d[i] !== 12'd0) bad = 1;
    tests++;
    if (bad) begin
      errors++; $display("FAIL clear_writes count %0d want %0d ascending zeros", wr_a.size(), N);
    end
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  task automatic test_load;
    int k, t;
    bit iv, bad;
    logic [11:0] d;
    wr_a.delete(); wr_d.delete();
    issue(OP_LOAD);
    k = 0; t = 0;
    while (k < N && t < 4 * N) begin
      @(negedge clk);
      iv = (t % 2 == 0);
      d  = iv ? 12'((k * 3) % 4096) : 12'($urandom);
      bus.in_valid = iv;
      bus.in_data  = d;
      #1;
      tests++;
      if (bus.in_ready !== 1'b1 || we !== iv) begin
        errors++; $display("FAIL load_ctl t=%0d in_ready=%0b we=%0b want 1 %0b", t, bus.in_ready, we, iv);
      end
      if (iv) begin
        tests++;
        if (waddr !== 10'(k) || wdata !== d) begin
          errors++; $display("FAIL load_write k=%0d addr=%0d data=%0d want %0d %0d", k, waddr, wdata, k, d);
        end
        ref_mem[k] = d;
        k++;
      end
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL load_done done=%0b busy=%0b in_ready=%0b want 1 0 0",
                         bus.done, bus.busy, bus.in_ready);
    end
    bad = (wr_a.size() != N);
    if (!bad) for (int i = 0; i < N; i++) if (wr_a[i] !== 10'(i) || wr_d[i] !== 12'((i * 3) % 4096)) bad = 1;
    tests++;
    if (bad) begin
      errors++; $display("FAIL load_writes count %0d want %0d with 3k data", wr_a.size(), N);
    end
  endtask

  task automatic test_dump;
    wr_a.delete();
    issue(OP_DUMP);
    run_dump(1'b1);
    tests++;
    if (wr_a.size() != 0) begin
      errors++; $display("FAIL dump_no_write got %0d writes want 0", wr_a.size());
    end
  endtask

  task automatic test_reserved;
    wr_a.delete();
    issue(OP_RSVD);
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rsvd_done done=%0b busy=%0b ready=%0b want 1 0 1",
                         bus.done, bus.busy, bus.cmd_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || wr_a.size() != 0) begin
      errors++; $display("FAIL rsvd_after done=%0b busy=%0b writes=%0d want 0 0 0",
                         bus.done, bus.busy, wr_a.size());
    end
  endtask

  task automatic test_reset_abort;
    int k;
    logic [11:0] d;
    wr_a.delete(); wr_d.delete();
    issue(OP_LOAD);
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      d = 12'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      ref_mem[k]   = d;
      k++;
    end
    @(negedge clk);
    bus.in_data = 12'($urandom);
    #1;
    tests++;
    if (waddr !== 10'd400 || we !== 1'b1) begin
      errors++; $display("FAIL abort_pre addr=%0d we=%0b want 400 1", waddr, we);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (we !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        waddr !== 10'd0 || raddr !== 10'd0 || wdata !== 12'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_outputs we=%0b in_ready=%0b busy=%0b ready=%0b addr=%0d data=%0d",
                         we, bus.in_ready, bus.busy, bus.cmd_ready, waddr, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL abort_idle i=%0d done=%0b busy=%0b want 0 0", i, bus.done, bus.busy);
      end
    end
    tests++;
    if (wr_a.size() != 400) begin
      errors++; $display("FAIL abort_writes got %0d want 400", wr_a.size());
    end
    issue(OP_DUMP);
    run_dump(1'b0);
  endtask

  task automatic test_back_to_back;
    int c;
    bit seen;
    issue(OP_CLEAR);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_DUMP;
    c = 0; seen = 0;
    while (!seen && c < N + 8) begin
      @(negedge clk); #1;
      c++;
      if (bus.done === 1'b1) seen = 1;
      else begin
        tests++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || we !== 1'b1) begin
          errors++; $display("FAIL b2b_ignored c=%0d ready=%0b busy=%0b we=%0b want 0 1 1",
                             c, bus.cmd_ready, bus.busy, we);
        end
      end
    end
    tests++;
    if (!seen || c != N + 1) begin
      errors++; $display("FAIL b2b_done_cycle got %0d want %0d", c, N + 1);
    end
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_at_done got %0b want 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    run_dump(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_clear;
    test_load;
    test_dump;
    test_reserved;
    test_reset_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/c_mem_ctrl.md
C_MEM_CTRL -- requirements
Module: c_mem_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 12, coefficient width in bits.
REQ-002 Parameter RAM_ADDR_BITS, default 10, coefficient RAM address width.
REQ-003 Parameter N, default 757, coefficient count per polynomial; 1 <= N <= 2**RAM_ADDR_BITS.
REQ-004 Port list, one per line:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 00 CLEAR, 01 LOAD, 10 DUMP, 11 reserved.
- cmd_ready  out  1  controller accepts a command.
- in_valid  in  1  LOAD coefficient valid.
- in_data  in  RAM_WIDTH  LOAD coefficient.
- in_ready  out  1  LOAD coefficient accepted.
- out_valid  out  1  DUMP coefficient valid.
- out_data  out  RAM_WIDTH  DUMP coefficient.
- out_ready  in  1  DUMP coefficient consumed.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  a command is in progress.
- ram_write_enable  out  1  drives the RAM write enable.
- ram_write_address  out  RAM_ADDR_BITS  drives the RAM write address.
- ram_input_data  out  RAM_WIDTH  drives the RAM write data.
- ram_read_address  out  RAM_ADDR_BITS  drives the RAM read address.
- ram_output_data  in  RAM_WIDTH  combinational RAM read data.

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, LOAD and DUMP, plus one address counter idx (RAM_ADDR_BITS bits).
REQ-006 cmd_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-007 In IDLE, cmd_valid with op 00/01/10 SHALL move to CLEAR/LOAD/DUMP with idx = 0; op 11 SHALL be consumed, leave the FSM in IDLE and pulse done in the next cycle.
REQ-008 CLEAR: ram_write_enable = 1, ram_write_address = idx, ram_input_data = 0 every cycle; idx increments each cycle; CLEAR lasts exactly N cycles.
REQ-009 LOAD: in_ready = 1; ram_write_enable = in_valid; ram_write_address = idx; ram_input_data = in_data; idx increments only on in_valid; in_valid low stalls with no write.
REQ-010 DUMP: ram_read_address = idx; out_data = ram_output_data, combinationally; out_valid = 1; idx increments only on out_ready; out_data stays stable while out_ready is low.
REQ-011 Outside their own states, in_ready, out_valid and ram_write_enable SHALL be 0; the address outputs SHALL be idx, and out_data and ram_input_data SHALL be 0.
REQ-012 On the transfer with idx == N-1, the FSM SHALL return to IDLE and pulse done in the following cycle; idx resets to 0 and SHALL never reach N.
REQ-013 A new command SHALL be accepted no earlier than the cycle after return to IDLE; back-to-back latency between commands SHALL be one cycle.
REQ-014 Each command SHALL issue exactly N RAM writes (CLEAR/LOAD) or N output transfers (DUMP), to addresses 0..N-1 in ascending order.
REQ-015 Addresses N..2**RAM_ADDR_BITS-1 SHALL never be written.

Reset
REQ-016 While rst is high: state = IDLE, idx = 0, done = 0, busy = 0, cmd_ready = 1, and all strobes, addresses and data outputs = 0.
REQ-017 Reset during an active command SHALL abort it immediately, with no further RAM writes and no done pulse; the RAM contents are not restored.

Structure
REQ-018 Package c_mem_pkg SHALL hold RAM_WIDTH, RAM_ADDR_BITS, N, the cmd_op encodings and the FSM state enumeration.
REQ-019 c_mem_ctrl SHALL contain no memory; a wrapper c_mem_sub SHALL instantiate c_mem_ctrl with the coefficient RAM module c as the sole sub-module.

Verification
REQ-020 Reset, then CLEAR -> 757 consecutive cycles with ram_write_enable = 1, addresses 0..756, data 0; done in cycle 758; busy low afterwards.
REQ-021 LOAD with in_data = idx*3 mod 4096 and in_valid toggling every other cycle -> exactly 757 writes; address k holds 3k mod 4096; no write on in_valid-low cycles.
REQ-022 DUMP after REQ-021 with out_ready randomly deasserted -> out_data sequence 0, 3, 6, ..., 2268; values held during stalls; one done pulse.
REQ-023 cmd_op = 11 -> no RAM writes, done pulse one cycle later, state remains IDLE.
REQ-024 rst asserted at LOAD idx = 400 -> outputs at reset values within the same cycle; later DUMP returns the loaded data at addresses 0..399.
REQ-025 cmd_valid held high with DUMP during CLEAR -> ignored until IDLE; DUMP accepted exactly one cycle after the CLEAR done pulse.
